shift_sequencer: RTL

Command-driven controller for the N-bit universal shift register functional unit. Accepts one operation per command (load, hold/readback, serial shift, rotate, arithmetic/logical shift) with a step count. Drives the register's select/data/enable/serial-in pins for exactly that many cycles, then returns the resulting register value on a response handshake. Sits between the I2C byte engine and the shift register; the only block allowed to drive that register.

---
 rtl/shift_seq_pkg.sv | 33 +++
 rtl/shift_sequencer_if.sv | 30 +++
 rtl/step_counter.sv | 32 +++
 rtl/shift_sequencer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types for the shift register sequencer.
//   sr_op_e   : operation code, identical to the shift register's S select encoding
//   state_e   : sequencer FSM states
//   steps_for : number of register update cycles a command needs
package shift_seq_pkg;

  typedef enum logic [2:0] {
    OpHold   = 3'd0,
    OpLoad   = 3'd1,
    OpShrSer = 3'd2,  // MSB <- serial in
    OpShlSer = 3'd3,  // LSB <- serial in
    OpRor    = 3'd4,
    OpRol    = 3'd5,
    OpAsr    = 3'd6,
    OpLsl    = 3'd7   // LSB <- 0
  } sr_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  // LOAD always takes one step, HOLD none; shifts are clamped to the register width.
  function automatic int unsigned steps_for(sr_op_e op, int unsigned count, int unsigned n);
    case (op)
      OpHold:  return 0;
      OpLoad:  return 1;
      default: return (count > n) ? n : count;
    endcase
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Command / response handshake between the I2C byte engine (master) and the
// shift sequencer (slave).
//   cmd_valid/cmd_ready : command handshake; cmd_op, cmd_count, cmd_data qualify it
//   rsp_valid/rsp_ready : response handshake; rsp_data is the register value
interface shift_sequencer_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N) + 1
);
  import shift_seq_pkg::*;

  logic          cmd_valid;
  logic          cmd_ready;
  sr_op_e        cmd_op;
  logic [CW-1:0] cmd_count;
  logic [N-1:0]  cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [N-1:0]  rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_count, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/step_counter.sv
// Loadable down counter for the remaining shift steps.
//   clk, rst  : clock, async active-high reset
//   load      : load load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one, saturating at zero
//   zero      : counter is zero
module step_counter #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && !zero) begin
      count_q <= count_q - CW'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven controller for the N-bit universal shift register. Accepts one
// operation per command, drives the register pins for exactly the required number
// of update cycles, then returns the register value on the response handshake.
//   clk, rst       : clock, async active-high reset
//   bus            : command/response handshake (slave side)
//   ser_in         : serial bit shifted in on SHR_SER / SHL_SER steps
//   ser_out(_valid): bit leaving the register on the current step
//   busy           : high outside IDLE
//   sr_*           : shift register select/data/enable/serial inputs and current value
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N) + 1
) (
  input  logic               clk,
  input  logic               rst,
  shift_sequencer_if.slave   bus,
  input  logic               ser_in,
  output logic               ser_out,
  output logic               ser_out_valid,
  output logic               busy,
  output sr_op_e             sr_s,
  output logic [N-1:0]       sr_d,
  output logic               sr_enable,
  output logic               sr_msb_in,
  output logic               sr_lsb_in,
  input  logic [N-1:0]       sr_q
);

  state_e        state_q, state_d;
  sr_op_e        op_q, op_d;
  logic [N-1:0]  data_q, data_d;
  logic [N-1:0]  rsp_data_q;
  logic [CW-1:0] steps;
  logic          accept;
  logic          cnt_load;
  logic          cnt_zero;
  logic          in_exec;

  assign steps    = CW'(steps_for(bus.cmd_op, 32'(bus.cmd_count), N));
  assign accept   = bus.cmd_valid && bus.cmd_ready;
  // Counter holds remaining steps minus one, so zero marks the final EXEC cycle.
  assign cnt_load = accept && (steps != '0);
  assign in_exec  = (state_q == StExec);

  step_counter #(
    .CW(CW)
  ) u_step_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (steps - CW'(1)),
    .dec      (in_exec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= OpHold;
      data_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      if (state_q == StResp) rsp_data_q <= sr_q;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d    = bus.cmd_op;
          data_d  = bus.cmd_data;
          state_d = (steps == '0) ? StResp : StExec;
        end
      end
      StExec: begin
        if (cnt_zero) state_d = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sr_enable     = in_exec;
    sr_s          = in_exec ? op_q : OpHold;
    sr_d          = in_exec ? data_q : '0;
    sr_msb_in     = in_exec && (op_q == OpShrSer) && ser_in;
    sr_lsb_in     = in_exec && (op_q == OpShlSer) && ser_in;
    ser_out       = 1'b0;
    ser_out_valid = 1'b0;
    if (in_exec) begin
      unique case (op_q)
        OpShrSer, OpRor, OpAsr: begin
          ser_out       = sr_q[0];
          ser_out_valid = 1'b1;
        end
        OpShlSer, OpRol, OpLsl: begin
          ser_out       = sr_q[N-1];
          ser_out_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // sr_q is frozen in RESP (enable low), so it is passed straight through there and
  // the captured copy keeps the value visible afterwards.
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_data  = (state_q == StResp) ? sr_q : rsp_data_q;
  assign bus.cmd_ready = (state_q == StIdle) && !rst;
  assign busy          = (state_q != StIdle);

endmodule
